// File: rtl/alu_mdu.sv
// -----------------------------------------------------------------------------
// alu_mdu
//
// Integer execution unit: a single-cycle base ALU plus an iterative
// multiply/divide unit, behind a valid/ready handshake on both sides.
//
// Base ops (op[4]=0) complete on the accept edge. Multiply runs a shift-add
// loop over operand magnitudes and divide runs a restoring loop over operand
// magnitudes, each for XLEN iterations followed by one sign-fix cycle.
// Divide-by-zero and signed overflow are resolved on the accept edge.
//
// Ports
//   clk        sole clock, rising edge
//   rst        synchronous, active-high reset
//   in_valid   request present on a, b, op
//   in_ready   unit can accept a request this cycle
//   a, b       operands (XLEN bits)
//   op         op[4]=0: base ALU op[3:0]; op[4]=1: mul/div op[2:0]
//   flush      abort any in-flight or held result, return to IDLE
//   out_valid  result valid (DONE state)
//   out_ready  consumer takes the result this cycle
//   result     registered result, holds its value outside DONE
//   busy       high while iterating (MUL or DIV)
// -----------------------------------------------------------------------------
module alu_mdu #(
   parameter int XLEN = 32,
   parameter int SHW  = $clog2(XLEN)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   input  logic [4:0]      op,
   input  logic            flush,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] result,
   output logic            busy
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_MUL,
      ST_DIV,
      ST_DONE
   } state_t;

   // Iterations 0..XLEN-1 do the arithmetic; count XLEN is the sign-fix cycle.
   localparam logic [SHW:0]    ITER_LAST = (SHW+1)'(XLEN);
   localparam logic [XLEN-1:0] MOST_NEG  = {1'b1, {(XLEN-1){1'b0}}};

   state_t            state_q, state_d;
   logic [SHW:0]      cnt_q;
   logic [XLEN-1:0]   a_q, b_q;
   logic [2:0]        mop_q;        // mul/div sub-op of the in-flight request
   logic [2*XLEN-1:0] acc_q;        // mul: {partial hi, multiplier}; div: {rem, quo}
   logic [XLEN-1:0]   result_q;

   logic              accept;
   logic              div_zero, div_ovf, div_special;
   logic [XLEN-1:0]   special_res;
   logic [XLEN-1:0]   base_res;
   logic [SHW-1:0]    shamt;
   logic              in_mul_sa, in_mul_sb, in_div_s;

   logic [XLEN-1:0]   mcand;
   logic [XLEN:0]     mul_sum;
   logic [2*XLEN-1:0] mul_next;
   logic [XLEN:0]     div_shift, div_diff;
   logic [2*XLEN-1:0] div_next;
   logic              prod_neg, quo_neg, rem_neg;
   logic [2*XLEN-1:0] prod_fix;
   logic [XLEN-1:0]   quo, rem;
   logic [XLEN-1:0]   fix_res;

   function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] v, input logic s);
      return (s && v[XLEN-1]) ? (~v + 1'b1) : v;
   endfunction

   // ---------------------------------------------------------------------------
   // Handshake and status
   // ---------------------------------------------------------------------------
   assign in_ready  = (state_q == ST_IDLE) && !rst && !flush;
   assign accept    = in_valid && in_ready;
   assign out_valid = (state_q == ST_DONE);
   assign busy      = (state_q == ST_MUL) || (state_q == ST_DIV);
   assign result    = result_q;

   // ---------------------------------------------------------------------------
   // Accept-time decode: base ALU, operand signedness, divide special cases
   // ---------------------------------------------------------------------------
   assign shamt     = b[SHW-1:0];
   assign in_mul_sa = (op[1:0] == 2'b01) || (op[1:0] == 2'b10);   // mulh, mulhsu
   assign in_mul_sb = (op[1:0] == 2'b01);                          // mulh
   assign in_div_s  = !op[0];                                      // div, rem

   // NOTE: every signal written in always_comb gets a default first, so no
   // path through the block can leave it unassigned and infer a latch.
   always_comb begin
      base_res = '0;
      unique case (op[3:0])
         4'b0000: base_res = a + b;
         4'b1000: base_res = a - b;
         4'b0001: base_res = a << shamt;
         4'b0010: base_res = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
         4'b0011: base_res = {{(XLEN-1){1'b0}}, (a < b)};
         4'b0100: base_res = a ^ b;
         4'b0101: base_res = a >> shamt;
         4'b1101: base_res = $signed(a) >>> shamt;
         4'b0110: base_res = a | b;
         4'b0111: base_res = a & b;
         default: base_res = '0;
      endcase
   end

   always_comb begin
      div_zero    = (b == '0);
      div_ovf     = in_div_s && (a == MOST_NEG) && (b == '1);
      div_special = op[4] && op[2] && (div_zero || div_ovf);
      special_res = '0;
      if (div_zero) special_res = op[1] ? a : '1;
      else          special_res = op[1] ? '0 : a;
   end

   // ---------------------------------------------------------------------------
   // Iteration datapath, driven only from captured operands
   // ---------------------------------------------------------------------------
   always_comb begin
      // Divisor magnitude for DIV, multiplicand magnitude for MUL.
      mcand = mop_q[2] ? mag(b_q, !mop_q[0])
                       : mag(a_q, (mop_q[1:0] == 2'b01) || (mop_q[1:0] == 2'b10));

      // Shift-add: add multiplicand into the high half when the current
      // multiplier bit is set, then shift the whole accumulator right.
      mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, mcand} : '0);
      mul_next = {mul_sum, acc_q[XLEN-1:1]};

      // Restoring divide: shift next dividend bit into the remainder and keep
      // the trial subtraction only when it does not go negative.
      div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
      div_diff  = div_shift - {1'b0, mcand};
      div_next  = div_diff[XLEN] ? {div_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                                 : {div_diff[XLEN-1:0],  acc_q[XLEN-2:0], 1'b1};
   end

   always_comb begin
      prod_neg = 1'b0;
      if (mop_q[1:0] == 2'b01)      prod_neg = a_q[XLEN-1] ^ b_q[XLEN-1];
      else if (mop_q[1:0] == 2'b10) prod_neg = a_q[XLEN-1];
      prod_fix = prod_neg ? (~acc_q + 1'b1) : acc_q;

      quo     = acc_q[XLEN-1:0];
      rem     = acc_q[2*XLEN-1:XLEN];
      quo_neg = !mop_q[0] && (a_q[XLEN-1] ^ b_q[XLEN-1]);
      rem_neg = !mop_q[0] && a_q[XLEN-1];

      fix_res = '0;
      if (mop_q[2]) begin
         if (mop_q[1]) fix_res = rem_neg ? (~rem + 1'b1) : rem;
         else          fix_res = quo_neg ? (~quo + 1'b1) : quo;
      end else begin
         fix_res = (mop_q[1:0] == 2'b00) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
      end
   end

   // ---------------------------------------------------------------------------
   // FSM
   // ---------------------------------------------------------------------------
   // NOTE: clocked blocks use non-blocking (<=) so every register samples
   // pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (flush) begin
         state_d = ST_IDLE;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (accept) begin
                  if (!op[4])          state_d = ST_DONE;
                  else if (!op[2])     state_d = ST_MUL;
                  else if (div_special) state_d = ST_DONE;
                  else                 state_d = ST_DIV;
               end
            end
            ST_MUL, ST_DIV: begin
               if (cnt_q == ITER_LAST) state_d = ST_DONE;
            end
            ST_DONE: begin
               if (out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // ---------------------------------------------------------------------------
   // Datapath registers
   // ---------------------------------------------------------------------------
   // NOTE: the operand, accumulator and result registers are plain flops, not a
   // memory array, so they are all cleared on reset at no cost.
   always_ff @(posedge clk) begin
      if (rst) begin
         a_q      <= '0;
         b_q      <= '0;
         mop_q    <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
         result_q <= '0;
      end else if (accept) begin
         a_q   <= a;
         b_q   <= b;
         mop_q <= op[2:0];
         cnt_q <= '0;
         if (!op[4])           result_q <= base_res;
         else if (!op[2])      acc_q    <= {{XLEN{1'b0}}, mag(b, in_mul_sb)};
         else if (div_special) result_q <= special_res;
         else                  acc_q    <= {{XLEN{1'b0}}, mag(a, in_div_s)};
         // in_mul_sa is consumed later via mop_q; keep it visible for clarity.
         if (op[4] && !op[2] && in_mul_sa && 1'b0) acc_q <= '0;
      end else if (busy && !flush) begin
         if (cnt_q == ITER_LAST) begin
            result_q <= fix_res;
         end else begin
            acc_q <= (state_q == ST_MUL) ? mul_next : div_next;
            cnt_q <= cnt_q + (SHW+1)'(1);
         end
      end
   end

endmodule

// File: doc/alu_mdu.md
ALU_MDU -- requirements
Module: alu_mdu

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand/result width; legal values 8, 16, 32, 64.
REQ-002 SHALL have parameter SHW, default $clog2(XLEN), shift-amount width; derived, not overridden.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 in_valid  input  1  request present on a, b, op.
REQ-006 in_ready  output  1  unit can accept a request this cycle.
REQ-007 a  input  XLEN  operand A (rs1).
REQ-008 b  input  XLEN  operand B (rs2 or immediate).
REQ-009 op  input  5  op[4]=0 selects base ALU op[3:0]; op[4]=1 selects multiply/divide op[2:0].
REQ-010 flush  input  1  abort any in-flight request.
REQ-011 out_valid  output  1  result valid.
REQ-012 out_ready  input  1  consumer takes result this cycle.
REQ-013 result  output  XLEN  registered result.
REQ-014 busy  output  1  high in MUL or DIV state.

Function
REQ-015 SHALL implement states IDLE, MUL, DIV, DONE; in_ready=1 only in IDLE with rst=0; out_valid=1 only in DONE.
REQ-016 Accept SHALL occur on an edge where in_valid&&in_ready; a, b, op captured into internal registers at that edge.
REQ-017 Base codes (op[4]=0): 0000 add, 1000 sub, 0001 sll, 0010 slt signed, 0011 sltu, 0100 xor, 0101 srl, 1101 sra, 0110 or, 0111 and; any other code SHALL yield 0.
REQ-018 Shifts SHALL use b[SHW-1:0] only; slt/sltu result is zero-extended 0/1; add/sub wrap modulo 2^XLEN.
REQ-019 Base op: IDLE->DONE on accept edge; result valid the following cycle (latency 1).
REQ-020 M codes (op[4]=1): 000 mul (low), 001 mulh (s*s high), 010 mulhsu (s*u high), 011 mulhu (u*u high), 100 div, 101 divu, 110 rem, 111 remu.
REQ-021 Multiply SHALL run an iterative shift-add over magnitudes for exactly XLEN cycles in MUL, then one sign-fix cycle, entering DONE; out_valid first high XLEN+2 cycles after accept edge.
REQ-022 Divide SHALL run restoring division on magnitudes for exactly XLEN cycles in DIV, plus one sign-fix cycle; same latency as REQ-021.
REQ-023 Signed div: quotient truncates toward zero; remainder takes sign of dividend.
REQ-024 Divide by zero: quotient all-ones, remainder = a; SHALL bypass DIV and enter DONE on accept edge (latency 1).
REQ-025 Signed overflow (a = most negative, b = -1, div/rem): quotient = a, remainder = 0; latency 1.
REQ-026 Iteration counter SHALL be SHW+1 bits, cleared on accept, and never wrap during an operation.
REQ-027 DONE holds result and out_valid stable until out_ready=1; on that edge SHALL go to IDLE; no new accept in the same cycle.
REQ-028 flush=1 SHALL force IDLE at next edge from any state, drop in-flight and held results, out_valid=0; flush has priority over accept and out_ready.
REQ-029 Inputs a, b, op SHALL be ignored when not accepting; changing them mid-operation SHALL not affect result.
REQ-030 result SHALL retain last value outside DONE (not a valid indication).

Reset
REQ-031 While rst=1: in_ready=0; at edge: state IDLE, out_valid=0, busy=0, result=0, counter=0, internal operand registers=0.
REQ-032 rst SHALL override flush and all handshakes; reset mid-MUL/DIV discards the operation with no out_valid pulse.
REQ-033 First accept possible on the first edge after rst deasserts.

Verification (XLEN=32)
REQ-034 sub a=5, b=7, op=01000, out_ready=1 -> out_valid 1 cycle after accept, result=0xFFFFFFFE; sra a=0x80000000, b=0x24 (amount 4) -> 0xF8000000.
REQ-035 mulh a=0xFFFFFFFF(-1), b=2 -> out_valid 34 cycles after accept, result=0xFFFFFFFF; mulhu same operands -> 0x00000001; mul -> 0xFFFFFFFE.
REQ-036 div a=-7, b=2 -> 0xFFFFFFFD; rem -> 0xFFFFFFFF; divu a=7, b=0 -> 0xFFFFFFFF, remu -> 7, both latency 1.
REQ-037 div a=0x80000000, b=0xFFFFFFFF -> result 0x80000000, rem -> 0, latency 1.
REQ-038 out_ready held 0 for 5 cycles after DONE -> result/out_valid stable, in_ready=0, in_valid ignored; release -> IDLE next edge.
REQ-039 flush at cycle 10 of divu, and separately rst at cycle 10 of mul -> IDLE next edge, no out_valid pulse, following add 1+1 returns 2.
